// File: rtl/beta_pcgen.sv
// Fetch PC generator for the beta core: issues in-order imem requests under a credit
// limit, buffers returned words and presents them to decode. Redirects flush wrong-path fetches.
module beta_pcgen #(
    parameter int                   DATAWIDTH  = 32,
    parameter logic [DATAWIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pcg_fetch_en_i,
    input  logic                 pcg_redirect_i,
    input  logic [DATAWIDTH-1:0] pcg_redirect_pc_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [31:0]          imem_rdata_i,
    output logic                 pcg_instr_valid_o,
    output logic [31:0]          pcg_instr_o,
    output logic [DATAWIDTH-1:0] pcg_instr_pc_o,
    input  logic                 pcg_instr_ready_i,
    output logic                 pcg_misalign_exc_o,
    output logic [DATAWIDTH-1:0] pcg_misalign_addr_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, EXC} state_e;

    state_e                state_q, state_d;
    logic [DATAWIDTH-1:0]  pc_q, pc_d;
    logic                  exc_q, exc_d;
    logic [DATAWIDTH-1:0]  maddr_q, maddr_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [PW-1:0]         fptr_q, fptr_d;
    logic [FIFO_DEPTH-1:0] filled_q, filled_d;
    logic [DATAWIDTH-1:0]  fpc_q   [FIFO_DEPTH];
    logic [31:0]           fdata_q [FIFO_DEPTH];

    logic          redir_act, misal, credit_ok, alloc, rv_fill, rv_drop, pop;
    logic [CW:0]   inflight;

    // Wrong-path responses still hold credit until they return, so drops count against depth.
    assign inflight  = {1'b0, drop_q} + {1'b0, cnt_q};
    assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);
    assign redir_act = pcg_redirect_i & (state_q != IDLE);
    assign misal     = |pcg_redirect_pc_i[1:0];
    assign imem_req_o  = (state_q == RUN) & pcg_fetch_en_i & ~pcg_redirect_i & credit_ok;
    assign imem_addr_o = pc_q;
    assign alloc     = imem_req_o & imem_gnt_i;
    assign rv_drop   = imem_rvalid_i & (drop_q != '0);
    assign rv_fill   = imem_rvalid_i & (drop_q == '0) & ~redir_act;
    assign pop       = filled_q[head_q] & pcg_instr_ready_i;

    assign pcg_instr_valid_o   = filled_q[head_q];
    assign pcg_instr_o         = fdata_q[head_q];
    assign pcg_instr_pc_o      = fpc_q[head_q];
    assign pcg_misalign_exc_o  = exc_q;
    assign pcg_misalign_addr_o = maddr_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        exc_d    = exc_q;
        maddr_d  = maddr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        filled_d = filled_q;
        cnt_d    = cnt_q + CW'(alloc) - CW'(pop);
        outst_d  = outst_q + CW'(alloc) - CW'(imem_rvalid_i);
        drop_d   = drop_q - CW'(rv_drop);

        case (state_q)
            IDLE:    if (pcg_fetch_en_i) state_d = RUN;
            RUN:     if (pcg_redirect_i && misal) state_d = EXC;
            EXC:     if (pcg_redirect_i && !misal) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (alloc) begin
            pc_d   = pc_q + DATAWIDTH'(4);
            tail_d = tail_q + 1'b1;
        end
        if (rv_fill) begin
            filled_d[fptr_q] = 1'b1;
            fptr_d           = fptr_q + 1'b1;
        end
        if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end

        // Flush: every response still owed by memory becomes a drop, including one arriving now.
        if (redir_act) begin
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fptr_d   = '0;
            cnt_d    = '0;
            outst_d  = outst_q - CW'(imem_rvalid_i);
            drop_d   = outst_q - CW'(imem_rvalid_i);
            if (misal) begin
                exc_d   = 1'b1;
                maddr_d = pcg_redirect_pc_i;
            end else begin
                exc_d   = 1'b0;
                maddr_d = '0;
                pc_d    = pcg_redirect_pc_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pc_q     <= BOOT_ADDR;
            exc_q    <= 1'b0;
            maddr_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            filled_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            exc_q    <= exc_d;
            maddr_q  <= maddr_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fptr_q   <= fptr_d;
            filled_q <= filled_d;
        end
    end

    // Payload storage needs no reset; the filled flags qualify it.
    always_ff @(posedge clk_i) begin
        if (alloc)   fpc_q[tail_q]   <= pc_q;
        if (rv_fill) fdata_q[fptr_q] <= imem_rdata_i;
    end
endmodule

// File: tb/tb_beta_pcgen.sv
// Directed bench for beta_pcgen: memory responder with programmable latency,
// expected-PC scoreboard popped by a monitor on each decode handshake.
module tb_beta_pcgen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b1;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ready = 1'b1;
    logic        exc;
    logic [31:0] maddr;

    int ncmp = 0;
    int nerr = 0;
    int gcnt = 0;
    int lat  = 1;
    logic [31:0] expq[$];

    logic [3:0]  vp;
    logic [31:0] ap [0:3];

    always #5 clk = ~clk;

    beta_pcgen #(.DATAWIDTH(32), .BOOT_ADDR(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .pcg_fetch_en_i(fetch_en), .pcg_redirect_i(redirect), .pcg_redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .pcg_instr_valid_o(ivalid), .pcg_instr_o(instr), .pcg_instr_pc_o(ipc),
        .pcg_instr_ready_i(ready),
        .pcg_misalign_exc_o(exc), .pcg_misalign_addr_o(maddr)
    );

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: fixed-latency in-order responder, reset together with the core.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vp <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                vp[i] <= vp[i+1];
                ap[i] <= ap[i+1];
            end
            vp[3] <= 1'b0;
            if (req && gnt) begin
                vp[lat-1] <= 1'b1;
                ap[lat-1] <= addr;
            end
        end
    end
    assign rvalid = vp[0];
    assign rdata  = ifn(ap[0]);

    always @(posedge clk) if (!rst && req && gnt) gcnt <= gcnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ivalid && ready) begin
            if (expq.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_instr: got pc %h, required no delivery", ipc);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                chk("deliv_pc", ipc, e);
                chk("deliv_instr", instr, ifn(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string nm, input int target);
        for (int i = 0; i < 80 && gcnt < target; i++) tick();
        chk(nm, gcnt, target);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 80 && expq.size() != 0; i++) tick();
        repeat (3) tick();
        chk(nm, expq.size(), 0);
        chk({nm, "_idle"}, {31'b0, ivalid}, 0);
    endtask

    task automatic push_list(input logic [31:0] l[$]);
        foreach (l[i]) expq.push_back(l[i]);
    endtask

    initial begin
        int g0;
        int k;
        // Reset state
        tick(); tick();
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_valid", {31'b0, ivalid}, 0);
        chk("rst_exc", {31'b0, exc}, 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_addr", addr, 32'hFFFF_FFFC);

        // Streaming from BOOT_ADDR with PC wrap, latency gnt->valid of 2 cycles
        rst = 1'b0;
        push_list('{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18});
        tick();
        g0 = gcnt;
        fetch_en = 1'b1;
        #1 chk("idle_noreq", {31'b0, req}, 0);
        tick();
        chk("first_req", {31'b0, req}, 1);
        chk("first_addr", addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", addr, 32'h0);
        chk("lat_not_yet", {31'b0, ivalid}, 0);
        tick();
        chk("lat_valid", {31'b0, ivalid}, 1);
        chk("lat_pc", ipc, 32'hFFFF_FFFC);
        wait_gnt("p1_gnts", g0 + 8);
        fetch_en = 1'b0;
        drain("p1_drain");

        // Backpressure: credit limits in-flight work to two
        ready = 1'b0;
        g0 = gcnt;
        fetch_en = 1'b1;
        repeat (6) tick();
        chk("bp_gnts", gcnt, g0 + 2);
        chk("bp_req", {31'b0, req}, 0);
        chk("bp_valid", {31'b0, ivalid}, 1);
        chk("bp_pc", ipc, 32'h1C);
        chk("bp_instr", instr, ifn(32'h1C));
        push_list('{32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30});
        ready = 1'b1;
        wait_gnt("p2_gnts", g0 + 6);
        fetch_en = 1'b0;
        drain("p2_drain");

        // Aligned redirect with two wrong-path fetches outstanding
        lat = 3;
        g0 = gcnt;
        fetch_en = 1'b1;
        wait_gnt("p3_pre", g0 + 2);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1 chk("redir_noreq", {31'b0, req}, 0);
        tick();
        redirect = 1'b0;
        push_list('{32'h100, 32'h104, 32'h108, 32'h10C});
        g0 = gcnt;
        k = 0;
        while (!req && k < 20) begin tick(); k++; end
        chk("redir_addr", addr, 32'h100);
        wait_gnt("p3_gnts", g0 + 4);
        fetch_en = 1'b0;
        drain("p3_drain");

        // Misaligned redirect, then recovery
        lat = 1;
        fetch_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h102;
        #1 chk("mis_noreq", {31'b0, req}, 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("mis_exc", {31'b0, exc}, 1);
        chk("mis_addr", maddr, 32'h102);
        chk("mis_req0", {31'b0, req}, 0);
        repeat (3) tick();
        chk("mis_hold_req", {31'b0, req}, 0);
        chk("mis_hold_exc", {31'b0, exc}, 1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        #1;
        chk("rec_exc", {31'b0, exc}, 0);
        chk("rec_req", {31'b0, req}, 1);
        chk("rec_addr", addr, 32'h200);
        push_list('{32'h200, 32'h204, 32'h208});
        g0 = gcnt;
        wait_gnt("p4_gnts", g0 + 3);
        fetch_en = 1'b0;
        drain("p4_drain");

        // Grant withheld: address stable, redirect withdraws the request
        gnt = 1'b0;
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", {31'b0, req}, 1);
            chk("stall_addr", addr, 32'h20C);
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        #1 chk("stall_withdraw", {31'b0, req}, 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("stall_newreq", {31'b0, req}, 1);
        chk("stall_newaddr", addr, 32'h300);
        push_list('{32'h300, 32'h304});
        g0 = gcnt;
        gnt = 1'b1;
        wait_gnt("p5_gnts", g0 + 2);
        fetch_en = 1'b0;
        drain("p5_drain");

        // Reset in the middle of a burst
        ready = 1'b0;
        g0 = gcnt;
        fetch_en = 1'b1;
        wait_gnt("p6_pre", g0 + 2);
        chk("p6_valid", {31'b0, ivalid}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, req}, 0);
        chk("mid_rst_valid", {31'b0, ivalid}, 0);
        chk("mid_rst_exc", {31'b0, exc}, 0);
        chk("mid_rst_addr", addr, 32'hFFFF_FFFC);
        tick();
        rst = 1'b0;
        ready = 1'b1;
        push_list('{32'hFFFF_FFFC, 32'h0});
        g0 = gcnt;
        wait_gnt("p6_gnts", g0 + 2);
        fetch_en = 1'b0;
        drain("p6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule

// File: doc/beta_pcgen.md
Name: beta_pcgen

Overview:
- PC generator and instruction-fetch front end for the beta core.
- Holds the architectural fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions and hands them to decode over a valid/ready interface.
- Consumes the redirect (next-PC / taken) produced by the execute-stage branch & jump unit: flushes wrong-path fetches and flags misaligned targets.

Parameters:
- DATAWIDTH, 32, width of PC, addresses and instruction data.
- BOOT_ADDR, 32'h0000_0000, PC value loaded at reset.
- FIFO_DEPTH, 2, max requests in flight plus buffered instructions (power of 2, >=2).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pcg_fetch_en_i  in  1  fetch enable; 0 suppresses new requests.
- pcg_redirect_i  in  1  redirect strobe from execute (taken branch, JAL, JALR).
- pcg_redirect_pc_i  in  DATAWIDTH  redirect target.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  DATAWIDTH  request address (= fetch PC).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid; responses return in order.
- imem_rdata_i  in  32  response instruction word.
- pcg_instr_valid_o  out  1  instruction available to decode.
- pcg_instr_o  out  32  instruction word.
- pcg_instr_pc_o  out  DATAWIDTH  PC of pcg_instr_o.
- pcg_instr_ready_i  in  1  decode accepts instruction.
- pcg_misalign_exc_o  out  1  misaligned redirect target exception.
- pcg_misalign_addr_o  out  DATAWIDTH  offending target address.

Behaviour:
- Reset (async, while rst_i=1):
  - pc=BOOT_ADDR; state=IDLE.
  - imem_req_o=0, pcg_instr_valid_o=0, pcg_misalign_exc_o=0, pcg_misalign_addr_o=0.
  - FIFO empty; outstanding and drop counters 0.
  - Reset mid-transaction discards everything; responses arriving after reset release are not dropped (the memory is reset with the core).
- States: IDLE, RUN, EXC.
  - IDLE -> RUN on first cycle with pcg_fetch_en_i=1.
  - RUN -> EXC on redirect with pcg_redirect_pc_i[1:0]!=0.
  - EXC -> RUN on redirect with an aligned target.
- Request rule (RUN only):
  - imem_req_o = fetch_en & ~redirect & (outstanding + buffered < FIFO_DEPTH); imem_addr_o = pc.
  - Address stable while req & ~gnt. A request may be withdrawn only in a redirect cycle.
- On gnt: pc <= pc+4 (mod 2^DATAWIDTH, wraps silently); allocate FIFO entry tagged with the granted PC; outstanding++.
- On rvalid with drop==0: fill oldest unfilled entry with imem_rdata_i; outstanding--.
- On rvalid with drop>0: discard data; drop--; outstanding--.
- Output:
  - pcg_instr_valid_o=1 when the FIFO head entry is filled. Output is registered: minimum latency gnt (cycle N) -> rvalid (N+1) -> valid_o (N+2).
  - valid/instr/pc held stable until pcg_instr_ready_i; pop on valid & ready. Simultaneous pop and fill in the same cycle is supported.
- Redirect (priority over everything, any state except IDLE):
  - Aligned target: pc <= target; FIFO flushed; pcg_instr_valid_o=0 next cycle; drop <= outstanding (including any response in the same cycle, which is discarded); new requests from the cycle after.
  - Misaligned target: same flush; no requests; pcg_misalign_exc_o=1 and pcg_misalign_addr_o=target registered next cycle and held in EXC.
  - Aligned redirect in EXC clears exc in the following cycle and resumes fetching.
- Redirect in IDLE is ignored.
- fetch_en falling: new requests stop; in-flight responses complete and are delivered normally.
- FIFO full (credit exhausted): req=0 until pop; no overflow possible by construction.

Test Plan:
- Reset, fetch_en=1, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> addresses 0x0,0x4,0x8...; instr_pc_o matches; first valid_o 2 cycles after first gnt.
- ready=0 for 6 cycles -> at most 2 requests issued, then req=0; instr/pc held stable; resumes when ready=1 with no loss or duplication.
- Redirect to 0x100 while 2 requests are in flight -> both responses dropped; next addr 0x100; first delivered pc=0x100.
- Redirect to 0x102 -> req=0, misalign_exc_o=1 and addr_o=0x102 next cycle; later redirect to 0x200 -> exc cleared, fetch resumes at 0x200.
- gnt withheld 3 cycles -> imem_addr_o stable; redirect during the wait -> req withdrawn that cycle, new address takes effect next cycle.
- BOOT_ADDR=0xFFFFFFFC -> second request addr 0x00000000 (wrap); rst_i asserted mid-burst -> all outputs 0 immediately, pc=BOOT_ADDR.
